// File: rtl/rf_sb.sv
// rf_sb: multi-port register file with scoreboard pending bits and optional write/clear bypass.
module rf_sb #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int NRD       = 2,
  parameter int BYPASS_EN = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]      o_rbusy,
  input  logic                i_wen0,
  input  logic [AW-1:0]       i_waddr0,
  input  logic [XLEN-1:0]     i_wdata0,
  input  logic                i_wen1,
  input  logic [AW-1:0]       i_waddr1,
  input  logic [XLEN-1:0]     i_wdata1,
  input  logic                i_alloc_en,
  input  logic [AW-1:0]       i_alloc_addr,
  output logic [AW:0]         o_busy_cnt
);
  logic [DEPTH-1:0][XLEN-1:0] rf_q, rf_d;
  logic [DEPTH-1:0]           busy_q, busy_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic                       w0, w1, al;
  assign w0 = i_wen0 && i_waddr0 != '0;
  assign w1 = i_wen1 && i_waddr1 != '0;
  assign al = i_alloc_en && i_alloc_addr != '0;
  // Port 1 is applied after port 0 so it wins; alloc is applied last so it wins over a clear.
  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (w0) begin
      rf_d[i_waddr0]   = i_wdata0;
      busy_d[i_waddr0] = 1'b0;
    end
    if (w1) begin
      rf_d[i_waddr1]   = i_wdata1;
      busy_d[i_waddr1] = 1'b0;
    end
    if (al) busy_d[i_alloc_addr] = 1'b1;
    cnt_d = '0;
    for (int i = 1; i < DEPTH; i++) cnt_d = cnt_d + (AW+1)'(busy_d[i]);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rf_q   <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign o_busy_cnt = cnt_q;
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic            m0, m1;
    logic [XLEN-1:0] d;
    assign a  = i_raddr[k*AW +: AW];
    assign m0 = BYPASS_EN != 0 && w0 && i_waddr0 == a;
    assign m1 = BYPASS_EN != 0 && w1 && i_waddr1 == a;
    assign d  = m1 ? i_wdata1 : m0 ? i_wdata0 : rf_q[a];
    // Gate on reset so bypassed write data cannot leak out while held in reset.
    assign o_rdata[k*XLEN +: XLEN] = i_rst ? '0 : d;
    assign o_rbusy[k] = !i_rst && busy_q[a] && !(m0 || m1);
  end
endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: directed checks of rf_sb without bypass, with bypass, and in a 4-port 64-bit configuration.
module tb_rf_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  raddr;
  logic        wen0, wen1, alloc_en;
  logic [4:0]  waddr0, waddr1, alloc_addr;
  logic [31:0] wdata0, wdata1;
  logic [63:0] rd0, rd1;
  logic [1:0]  rb0, rb1;
  logic [5:0]  cnt0, cnt1;
  logic [15:0]  raddr2;
  logic         wen2;
  logic [3:0]   waddr2;
  logic [63:0]  wdata2;
  logic [255:0] rd2;
  logic [3:0]   rb2;
  logic [4:0]   cnt2;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  rf_sb u0 (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rd0), .o_rbusy(rb0),
    .i_wen0(wen0), .i_waddr0(waddr0), .i_wdata0(wdata0),
    .i_wen1(wen1), .i_waddr1(waddr1), .i_wdata1(wdata1),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_busy_cnt(cnt0));
  rf_sb #(.BYPASS_EN(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rd1), .o_rbusy(rb1),
    .i_wen0(wen0), .i_waddr0(waddr0), .i_wdata0(wdata0),
    .i_wen1(wen1), .i_waddr1(waddr1), .i_wdata1(wdata1),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_busy_cnt(cnt1));
  rf_sb #(.XLEN(64), .DEPTH(16), .NRD(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr2), .o_rdata(rd2), .o_rbusy(rb2),
    .i_wen0(wen2), .i_waddr0(waddr2), .i_wdata0(wdata2),
    .i_wen1(1'b0), .i_waddr1(4'd0), .i_wdata1(64'd0),
    .i_alloc_en(1'b0), .i_alloc_addr(4'd0), .o_busy_cnt(cnt2));
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wen0 = 1'b0;
    wen1 = 1'b0;
    alloc_en = 1'b0;
  endtask
  initial begin
    raddr = {5'd5, 5'd5};
    idle();
    waddr0 = '0; waddr1 = '0; alloc_addr = '0; wdata0 = '0; wdata1 = '0;
    raddr2 = {4{4'd15}}; wen2 = 1'b0; waddr2 = '0; wdata2 = '0;
    #2;
    chk("reset_cnt", 256'(cnt0), 256'd0);
    chk("reset_rdata", 256'(rd0), 256'd0);
    chk("reset_rbusy", 256'(rb0), 256'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    #1;
    chk("nobyp_same_cycle", 256'(rd0), 256'd0);
    chk("byp_same_cycle", 256'(rd1), 256'({2{32'hDEADBEEF}}));
    tick(); idle();
    #1;
    chk("nobyp_next_cycle", 256'(rd0), 256'({2{32'hDEADBEEF}}));
    raddr = {5'd7, 5'd7};
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    #1;
    chk("byp_dual_write", 256'(rd1), 256'({2{32'h22}}));
    chk("nobyp_dual_same", 256'(rd0), 256'd0);
    tick(); idle();
    #1;
    chk("dual_write_p1_wins", 256'(rd0), 256'({2{32'h22}}));
    raddr = {5'd0, 5'd0};
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    #1;
    chk("byp_r0_never", 256'(rd1), 256'd0);
    tick(); idle();
    #1;
    chk("r0_hardwired", 256'(rd0), 256'd0);
    chk("r0_cnt", 256'(cnt0), 256'd0);
    raddr = {5'd9, 5'd3};
    alloc_en = 1'b1; alloc_addr = 5'd3;
    #1;
    chk("alloc_not_same_cycle_nobyp", 256'(rb0), 256'd0);
    chk("alloc_not_same_cycle_byp", 256'(rb1), 256'd0);
    tick();
    alloc_addr = 5'd9;
    tick(); idle();
    #1;
    chk("alloc2_cnt", 256'(cnt0), 256'd2);
    chk("alloc2_rbusy", 256'(rb0), 256'(2'b11));
    chk("alloc2_rbusy_byp", 256'(rb1), 256'(2'b11));
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33;
    #1;
    chk("byp_write_clears_busy", 256'(rb1), 256'(2'b10));
    chk("nobyp_write_keeps_busy", 256'(rb0), 256'(2'b11));
    tick(); idle();
    #1;
    chk("write_clear_cnt", 256'(cnt0), 256'd1);
    chk("write_clear_rbusy", 256'(rb0), 256'(2'b10));
    alloc_en = 1'b1; alloc_addr = 5'd9;
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    #1;
    chk("byp_write_alloc_busy", 256'(rb1), 256'd0);
    tick(); idle();
    #1;
    chk("alloc_wins_cnt", 256'(cnt0), 256'd1);
    chk("alloc_wins_rbusy", 256'(rb0), 256'(2'b10));
    chk("alloc_wins_data", 256'(rd0), 256'({32'h99, 32'h33}));
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick(); idle();
    chk("alloc_r4_cnt", 256'(cnt0), 256'd2);
    raddr = {5'd7, 5'd5};
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hABC;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 256'(cnt0), 256'd0);
    chk("async_rst_rdata", 256'(rd0), 256'd0);
    chk("async_rst_rdata_byp", 256'(rd1), 256'd0);
    chk("async_rst_rbusy_byp", 256'(rb1), 256'd0);
    #1 rst = 1'b0;
    tick(); idle();
    #1;
    chk("first_edge_after_rst", 256'(rd0), 256'({32'h0, 32'hABC}));
    chk("first_edge_after_rst_cnt", 256'(cnt0), 256'd0);
    for (int i = 1; i < 32; i++) begin
      alloc_en = 1'b1; alloc_addr = 5'(i);
      tick();
    end
    idle();
    chk("fill_cnt", 256'(cnt0), 256'd31);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick(); idle();
    chk("alloc_r0_cnt", 256'(cnt0), 256'd31);
    chk("alloc_r0_cnt_byp", 256'(cnt1), 256'd31);
    wen2 = 1'b1; waddr2 = 4'd15; wdata2 = 64'h0123456789ABCDEF;
    tick();
    wen2 = 1'b0;
    #1;
    chk("nrd4_all_ports", rd2, 256'({4{64'h0123456789ABCDEF}}));
    chk("nrd4_rbusy", 256'(rb2), 256'd0);
    chk("nrd4_cnt", 256'(cnt2), 256'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rf_sb.md
RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, register count; power of two, >=2; AW = log2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2, number of asynchronous read ports, 1..8.
REQ-004 SHALL have parameter BYPASS_EN, default 0; 1 forwards same-cycle write data and scoreboard clears to read ports.
REQ-005 SHALL have port i_clk  input  1  single global clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_raddr  input  NRD*AW  read addresses; port k in bits [k*AW +: AW].
REQ-008 SHALL have port o_rdata  output  NRD*XLEN  read data; port k in bits [k*XLEN +: XLEN].
REQ-009 SHALL have port o_rbusy  output  NRD  scoreboard pending bit of each read address.
REQ-010 SHALL have ports i_wen0 / i_waddr0 / i_wdata0  input  1 / AW / XLEN  write port 0.
REQ-011 SHALL have ports i_wen1 / i_waddr1 / i_wdata1  input  1 / AW / XLEN  write port 1.
REQ-012 SHALL have ports i_alloc_en / i_alloc_addr  input  1 / AW  mark destination register pending.
REQ-013 SHALL have port o_busy_cnt  output  AW+1  number of registers currently pending.

Function
REQ-014 SHALL hardwire register 0: reads return 0, o_rbusy 0; writes and allocs to address 0 ignored.
REQ-015 SHALL drive o_rdata and o_rbusy combinationally from i_raddr and current state.
REQ-016 SHALL update a register on the edge after i_wenN=1 with nonzero address; data visible next cycle.
REQ-017 SHALL, when both write ports target the same nonzero address in one cycle, store i_wdata1 (port 1 wins).
REQ-018 SHALL set the pending bit of i_alloc_addr on the edge after i_alloc_en=1 (nonzero address).
REQ-019 SHALL clear the pending bit of any address written by either write port on that edge.
REQ-020 SHALL, when alloc and a write target the same address in one cycle, leave the bit set (alloc wins).
REQ-021 SHALL keep o_busy_cnt equal to the population count of pending bits, updated on the same edge, never exceeding DEPTH-1.
REQ-022 SHALL, with BYPASS_EN=0, show no same-cycle effect of writes or allocs on read outputs.
REQ-023 SHALL, with BYPASS_EN=1, return i_wdata1 if i_wen1 matches the read address, else i_wdata0 if i_wen0 matches, else stored data; address 0 is never bypassed.
REQ-024 SHALL, with BYPASS_EN=1, report o_rbusy=0 for an address being written this cycle, regardless of its stored pending bit.
REQ-025 SHALL NOT reflect a same-cycle alloc on o_rbusy in either mode.
REQ-026 SHALL tolerate all read ports addressing the same register simultaneously.

Reset
REQ-027 SHALL, while i_rst=1, asynchronously clear all registers to 0, all pending bits to 0, and o_busy_cnt to 0.
REQ-028 SHALL, while i_rst=1, drive o_rdata=0 and o_rbusy=0 on all ports, and ignore writes and allocs.
REQ-029 SHALL, when i_rst deasserts, accept a write or alloc on the first rising edge after deassertion.
REQ-030 SHALL, if i_rst asserts mid-cycle, discard any write or alloc pending for the next edge.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to r5 via port 0 -> r5 reads 0 that cycle and 0xDEADBEEF next cycle (BYPASS_EN=0), and 0xDEADBEEF the same cycle (BYPASS_EN=1).
REQ-032 SHALL cover: port 0 writes 0x11 and port 1 writes 0x22 to r7 in the same cycle -> r7 reads 0x22; a write of 0xFFFFFFFF to r0 -> r0 reads 0.
REQ-033 SHALL cover: alloc r3 and r9 -> o_busy_cnt=2 and o_rbusy=1 on both; write r3 -> o_busy_cnt=1; alloc r9 and write r9 together -> r9 stays busy, o_busy_cnt=1.
REQ-034 SHALL cover: alloc r4, then assert i_rst between clock edges -> o_busy_cnt=0 and all o_rdata=0 immediately, with no edge required.
REQ-035 SHALL cover: NRD=4, DEPTH=16, XLEN=64 -> all four ports read r15=0x0123456789ABCDEF written the prior cycle.
REQ-036 SHALL cover: fill r1..r(DEPTH-1) with allocs -> o_busy_cnt=DEPTH-1; an alloc of r0 then leaves the count unchanged.
